// File: rtl/bram_mem_pkg.sv
// -----------------------------------------------------------------------------
// bram_mem_pkg
// Shared types and constants for the block-RAM memCtrl responder.
//   MemRespState  : responder FSM state encoding
//   MEM_OOR_DATA  : byte returned for a read outside the implemented range
//   MEM_WAIT_MAX  : largest supported number of inserted wait cycles
//   clamp_wait()  : folds a requested wait count into 0..MEM_WAIT_MAX
// -----------------------------------------------------------------------------
package bram_mem_pkg;

    typedef enum bit [2:0] {
        mrsIdle   = 3'd0,
        mrsWait   = 3'd1,
        mrsAccess = 3'd2,
        mrsDone   = 3'd3
    } MemRespState;

    localparam logic [7:0] MEM_OOR_DATA = 8'hFF;
    localparam int         MEM_WAIT_MAX = 15;

    // The wait counter is 4 bits wide, so out-of-range settings are folded
    // back into what the counter can actually represent.
    function automatic int clamp_wait(input int w);
        if (w < 0) begin
            return 0;
        end
        if (w > MEM_WAIT_MAX) begin
            return MEM_WAIT_MAX;
        end
        return w;
    endfunction

endpackage

// File: rtl/sp_bram.sv
// -----------------------------------------------------------------------------
// sp_bram
// Single-port synchronous byte RAM with a registered read (1-cycle latency).
// Read-first: dout shows the old contents of addr when a write hits it.
// No reset on the array or the read register so the tools map it onto
// block RAM.
//   clkSys : clock, rising edge
//   we     : write enable
//   addr   : byte address (DEPTH_LOG2 bits)
//   din    : write data
//   dout   : read data, registered
// -----------------------------------------------------------------------------
module sp_bram #(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clkSys,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            din,
    output logic [7:0]            dout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0] mem_reg [DEPTH];
    logic [7:0] dout_reg;

    always_ff @(posedge clkSys) begin
        if (we) begin
            mem_reg[addr] <= din;
        end
        dout_reg <= mem_reg[addr];
    end

    assign dout = dout_reg;

endmodule

// File: rtl/bram_mem_responder.sv
// -----------------------------------------------------------------------------
// bram_mem_responder
// Responder side of the memCtrl request interface, backed by on-chip block
// RAM. An initiator pulls i_cs low to start an access; the block answers with
// o_busy for WAIT_CYCLES+2 cycles and, for reads, raises o_dataReady with the
// byte in the same cycle o_busy falls. Addresses beyond the implemented
// 2**DEPTH_LOG2 bytes are flagged on o_addrErr: writes are dropped and reads
// return 8'hFF.
//
// Ports:
//   clkSys         : clock, rising edge
//   rst            : asynchronous active-low reset
//   i_cs           : chip select, active-low; must be seen high between
//                    requests (holding it low never re-triggers)
//   i_write        : 1 = write, 0 = read (sampled at accept)
//   i_address      : byte address (sampled at accept)
//   i_dataToWrite  : write byte (sampled at accept)
//   o_dataRead     : read byte, valid while o_dataReady = 1
//   o_busy         : request in progress
//   o_dataReady    : read result available; held until the next accept
//   o_stats        : {readCount, writeCount}, only with
//                    BRAM_MEM_RESPONDER_STATS_EN defined
//   o_addrErr      : 1-cycle pulse when the finished request was out of range
//
// Build option: define BRAM_MEM_RESPONDER_STATS_EN to add o_stats with
// saturating 16-bit in-range read/write counters.
// -----------------------------------------------------------------------------
module bram_mem_responder
    import bram_mem_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DEPTH_LOG2  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clkSys,
    input  logic              rst,
    input  logic              i_cs,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [7:0]        i_dataToWrite,
    output logic [7:0]        o_dataRead,
    output logic              o_busy,
    output logic              o_dataReady,
`ifdef BRAM_MEM_RESPONDER_STATS_EN
    output logic [31:0]       o_stats,
`endif
    output logic              o_addrErr
);

    localparam int         WAIT_EFF  = clamp_wait(WAIT_CYCLES);
    // Counter is loaded with WAIT_EFF-1 so the WAIT state lasts WAIT_EFF cycles.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_EFF > 0) ? (WAIT_EFF - 1) : 0);

    MemRespState           state_reg,    state_next;
    logic                  armed_reg,    armed_next;
    logic [3:0]            wait_cnt_reg, wait_cnt_next;
    logic                  wr_reg,       wr_next;
    logic [DEPTH_LOG2-1:0] addr_reg,     addr_next;
    logic [7:0]            wdata_reg,    wdata_next;
    logic                  oor_reg,      oor_next;
    logic                  busy_reg,     busy_next;
    logic                  rdy_reg,      rdy_next;
    logic [7:0]            rdata_reg,    rdata_next;
    logic                  addr_err_reg, addr_err_next;

    logic                  addr_oor;
    logic                  ram_we;
    logic [7:0]            ram_dout;

    // Any address bit at or above DEPTH_LOG2 means the byte is not
    // implemented; there is deliberately no wrap-around aliasing.
    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_range_chk
            assign addr_oor = |i_address[ADDR_W-1:DEPTH_LOG2];
        end else begin : g_range_full
            assign addr_oor = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clkSys or negedge rst) begin
        if (!rst) begin
            state_reg    <= mrsIdle;
            armed_reg    <= 1'b1;
            wait_cnt_reg <= 4'd0;
            wr_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 8'h00;
            oor_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            rdy_reg      <= 1'b0;
            rdata_reg    <= 8'h00;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            armed_reg    <= armed_next;
            wait_cnt_reg <= wait_cnt_next;
            wr_reg       <= wr_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            oor_reg      <= oor_next;
            busy_reg     <= busy_next;
            rdy_reg      <= rdy_next;
            rdata_reg    <= rdata_next;
            addr_err_reg <= addr_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        armed_next    = armed_reg;
        wait_cnt_next = wait_cnt_reg;
        wr_next       = wr_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        oor_next      = oor_reg;
        busy_next     = busy_reg;
        rdy_next      = rdy_reg;
        rdata_next    = rdata_reg;
        addr_err_next = 1'b0;

        // Re-arm whenever chip select is seen high, in any state, so a
        // gap during the access already qualifies the next request.
        if (i_cs) begin
            armed_next = 1'b1;
        end

        case (state_reg)
            mrsIdle: begin
                if (!i_cs && armed_reg) begin
                    armed_next = 1'b0;
                    wr_next    = i_write;
                    addr_next  = i_address[DEPTH_LOG2-1:0];
                    wdata_next = i_dataToWrite;
                    oor_next   = addr_oor;
                    busy_next  = 1'b1;
                    rdy_next   = 1'b0;
                    if (WAIT_EFF > 0) begin
                        state_next    = mrsWait;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = mrsAccess;
                    end
                end
            end

            mrsWait: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = mrsAccess;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end

            // RAM operation is issued combinationally from this state;
            // read data appears on ram_dout during DONE.
            mrsAccess: begin
                state_next = mrsDone;
            end

            mrsDone: begin
                busy_next     = 1'b0;
                addr_err_next = oor_reg;
                if (!wr_reg) begin
                    rdy_next   = 1'b1;
                    rdata_next = oor_reg ? MEM_OOR_DATA : ram_dout;
                end
                state_next = mrsIdle;
            end

            default: begin
                state_next = mrsIdle;
            end
        endcase
    end

    // Writes to unimplemented addresses never reach the array, so they
    // cannot alias onto a low address.
    assign ram_we = (state_reg == mrsAccess) && wr_reg && !oor_reg;

    sp_bram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clkSys (clkSys),
        .we     (ram_we),
        .addr   (addr_reg),
        .din    (wdata_reg),
        .dout   (ram_dout)
    );

    assign o_busy      = busy_reg;
    assign o_dataReady = rdy_reg;
    assign o_dataRead  = rdata_reg;
    assign o_addrErr   = addr_err_reg;

`ifdef BRAM_MEM_RESPONDER_STATS_EN
    // Slot 0 counts in-range writes, slot 1 in-range reads; both saturate.
    logic [1:0] stat_hit;

    assign stat_hit[0] = (state_reg == mrsDone) && !oor_reg &&  wr_reg;
    assign stat_hit[1] = (state_reg == mrsDone) && !oor_reg && !wr_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] count_reg;

        always_ff @(posedge clkSys or negedge rst) begin
            if (!rst) begin
                count_reg <= 16'h0000;
            end else if (stat_hit[gi] && (count_reg != 16'hFFFF)) begin
                count_reg <= count_reg + 16'h0001;
            end
        end

        assign o_stats[gi*16 +: 16] = count_reg;
    end
`endif

endmodule

// File: tb/tb_bram_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_bram_mem_responder
// Two responders share clock and reset: index 0 with WAIT_CYCLES=2 and index 1
// with WAIT_CYCLES=0. A transaction-level model (associative byte memory keyed
// by responder and address, plus access counters) predicts every response.
// -----------------------------------------------------------------------------
module tb_bram_mem_responder;

    localparam int WAITS [2] = '{2, 0};

    logic        clkSys = 1'b0;
    logic        rst;
    logic        cs     [2];
    logic        wr_s   [2];
    logic [23:0] addr_s [2];
    logic [7:0]  din_s  [2];
    logic [7:0]  rdata  [2];
    logic        busy   [2];
    logic        rdy    [2];
    logic        aerr   [2];
`ifdef BRAM_MEM_RESPONDER_STATS_EN
    logic [31:0] stats  [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model [int];
    int         rd_cnt [2];
    int         wr_cnt [2];

    always #5 clkSys = ~clkSys;

    bram_mem_responder #(.ADDR_W(24), .DEPTH_LOG2(16), .WAIT_CYCLES(2)) dut0 (
        .clkSys        (clkSys),
        .rst           (rst),
        .i_cs          (cs[0]),
        .i_write       (wr_s[0]),
        .i_address     (addr_s[0]),
        .i_dataToWrite (din_s[0]),
        .o_dataRead    (rdata[0]),
        .o_busy        (busy[0]),
        .o_dataReady   (rdy[0]),
`ifdef BRAM_MEM_RESPONDER_STATS_EN
        .o_stats       (stats[0]),
`endif
        .o_addrErr     (aerr[0])
    );

    bram_mem_responder #(.ADDR_W(24), .DEPTH_LOG2(16), .WAIT_CYCLES(0)) dut1 (
        .clkSys        (clkSys),
        .rst           (rst),
        .i_cs          (cs[1]),
        .i_write       (wr_s[1]),
        .i_address     (addr_s[1]),
        .i_dataToWrite (din_s[1]),
        .o_dataRead    (rdata[1]),
        .o_busy        (busy[1]),
        .o_dataReady   (rdy[1]),
`ifdef BRAM_MEM_RESPONDER_STATS_EN
        .o_stats       (stats[1]),
`endif
        .o_addrErr     (aerr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int mkey(input int d, input logic [23:0] a);
        return (d << 24) + int'(a);
    endfunction

    function automatic bit is_oor(input logic [23:0] a);
        return int'(a) >= 65536;
    endfunction

    // Garbage on the request lines while busy; the responder must ignore it.
    task automatic scramble(input int d);
        cs[d]     = 1'($urandom_range(0, 1));
        wr_s[d]   = 1'($urandom_range(0, 1));
        addr_s[d] = 24'($urandom);
        din_s[d]  = 8'($urandom);
    endtask

    // One complete request. Entered and left at a negedge with the responder
    // idle and chip select high. hold=1 keeps i_cs low for 20 cycles after
    // completion to prove that no second access starts.
    task automatic do_req(input int d, input bit wr, input logic [23:0] a,
                          input logic [7:0] dat, input bit hold);
        int         busy_n;
        int         rerise;
        bit         oor;
        logic [7:0] exp_d;

        oor   = is_oor(a);
        exp_d = 8'h00;
        if (!wr) begin
            exp_d = oor ? 8'hFF : model[mkey(d, a)];
        end

        @(negedge clkSys);
        cs[d]     = 1'b0;
        wr_s[d]   = wr;
        addr_s[d] = a;
        din_s[d]  = dat;
        @(posedge clkSys);
        #1;
        if (!hold) begin
            cs[d] = 1'b1;
        end
        @(negedge clkSys);
        check($sformatf("d%0d busy_rise", d), 32'(busy[d]), 32'd1);
        check($sformatf("d%0d rdy_clear", d), 32'(rdy[d]), 32'd0);

        busy_n = 0;
        while (busy[d] && busy_n < 40) begin
            busy_n++;
            if (!hold) begin
                scramble(d);
            end
            @(negedge clkSys);
        end
        if (!hold) begin
            cs[d] = 1'b1;
        end
        check($sformatf("d%0d busy_len", d), 32'(busy_n), 32'(WAITS[d] + 2));
        check($sformatf("d%0d rdy_at_fall", d), 32'(rdy[d]), 32'(!wr));
        check($sformatf("d%0d aerr_at_fall", d), 32'(aerr[d]), 32'(oor));
        if (!wr) begin
            check($sformatf("d%0d rdata %06h", d, a), 32'(rdata[d]), 32'(exp_d));
        end

        if (wr && !oor) begin
            model[mkey(d, a)] = dat;
        end
        if (!oor) begin
            if (wr) wr_cnt[d]++;
            else    rd_cnt[d]++;
        end

        if (hold) begin
            rerise = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clkSys);
                if (busy[d]) rerise++;
            end
            check($sformatf("d%0d cs_hold_no_retrigger", d), 32'(rerise), 32'd0);
            cs[d] = 1'b1;
        end

        @(negedge clkSys);
        check($sformatf("d%0d aerr_pulse_end", d), 32'(aerr[d]), 32'd0);
        if (!wr) begin
            check($sformatf("d%0d rdy_hold", d), 32'(rdy[d]), 32'd1);
            check($sformatf("d%0d rdata_hold", d), 32'(rdata[d]), 32'(exp_d));
        end

        $display("[%0t] d%0d %s addr=%06h wdata=%02h rdata=%02h rdy=%0b busy_cycles=%0d aerr_seen=%0b",
                 $time, d, wr ? "WR" : "RD", a, dat, rdata[d], rdy[d], busy_n, oor);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d busy", tag, d),  32'(busy[d]),  32'd0);
            check($sformatf("%s d%0d rdy", tag, d),   32'(rdy[d]),   32'd0);
            check($sformatf("%s d%0d rdata", tag, d), 32'(rdata[d]), 32'd0);
            check($sformatf("%s d%0d aerr", tag, d),  32'(aerr[d]),  32'd0);
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            rd_cnt[d] = 0;
            wr_cnt[d] = 0;
        end
    endtask

`ifdef BRAM_MEM_RESPONDER_STATS_EN
    task automatic check_stats(input string tag, input int d);
        logic [15:0] er;
        logic [15:0] ew;
        er = (rd_cnt[d] > 65535) ? 16'hFFFF : 16'(rd_cnt[d]);
        ew = (wr_cnt[d] > 65535) ? 16'hFFFF : 16'(wr_cnt[d]);
        check($sformatf("%s d%0d stats", tag, d), stats[d], {er, ew});
    endtask
`endif

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cs[d]     = 1'b1;
            wr_s[d]   = 1'b0;
            addr_s[d] = 24'h0;
            din_s[d]  = 8'h0;
        end
        clear_counts();

        repeat (3) @(negedge clkSys);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clkSys);

        // Write then read back the top of the implemented range.
        do_req(0, 1'b1, 24'h00FFFC, 8'hAA, 1'b0);
        do_req(0, 1'b0, 24'h00FFFC, 8'h00, 1'b0);

        // Chip select held low after a write: exactly one access.
        do_req(0, 1'b1, 24'h000010, 8'h5A, 1'b1);
        do_req(0, 1'b0, 24'h000010, 8'h00, 1'b0);

        // Out-of-range write must not alias onto address 0.
        do_req(0, 1'b1, 24'h000000, 8'h3C, 1'b0);
        do_req(0, 1'b1, 24'h010000, 8'hC3, 1'b0);
        do_req(0, 1'b0, 24'h010000, 8'h00, 1'b0);
        do_req(0, 1'b0, 24'h000000, 8'h00, 1'b0);

        // Reset while a read is in its WAIT phase.
        @(negedge clkSys);
        cs[0]     = 1'b0;
        wr_s[0]   = 1'b0;
        addr_s[0] = 24'h00FFFC;
        @(posedge clkSys);
        #1;
        cs[0] = 1'b1;
        @(negedge clkSys);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clkSys);
        check_reset_outputs("mid_rst_hold");
        rst = 1'b1;
        clear_counts();
        @(negedge clkSys);
        do_req(0, 1'b0, 24'h00FFFC, 8'h00, 1'b0);

        // Zero-wait responder: back-to-back reads.
        do_req(1, 1'b1, 24'h000300, 8'h11, 1'b0);
        do_req(1, 1'b1, 24'h000301, 8'h22, 1'b0);
        do_req(1, 1'b0, 24'h000300, 8'h00, 1'b0);
        do_req(1, 1'b0, 24'h000301, 8'h00, 1'b0);

        // Randomized traffic on both responders.
        for (int t = 0; t < 80; t++) begin
            int          d;
            bit          wr;
            logic [23:0] a;
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                a = 24'h010000 + 24'($urandom_range(0, 24'hFEFFFF));
            end else begin
                a = ($urandom_range(0, 1) != 0 ? 24'h00FFC0 : 24'h000000)
                    + 24'($urandom_range(0, 63));
            end
            wr = ($urandom_range(0, 1) != 0);
            if (!wr && !is_oor(a) && !model.exists(mkey(d, a))) begin
                wr = 1'b1;
            end
            do_req(d, wr, a, 8'($urandom), 1'b0);
        end

`ifdef BRAM_MEM_RESPONDER_STATS_EN
        check_stats("random", 0);
        check_stats("random", 1);

        @(negedge clkSys);
        rst = 1'b0;
        @(negedge clkSys);
        rst = 1'b1;
        clear_counts();
        @(negedge clkSys);
        do_req(0, 1'b1, 24'h000020, 8'h01, 1'b0);
        do_req(0, 1'b1, 24'h000021, 8'h02, 1'b0);
        do_req(0, 1'b1, 24'h000022, 8'h03, 1'b0);
        do_req(0, 1'b0, 24'h000020, 8'h00, 1'b0);
        do_req(0, 1'b0, 24'h000022, 8'h00, 1'b0);
        do_req(0, 1'b0, 24'h123456, 8'h00, 1'b0);
        check("stats_directed", stats[0], 32'h0002_0003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
